// File: rtl/matmul_engine_if.sv
// Bundle for the matmul_engine control handshake and memory ports.
// The slave modport belongs to the engine; the master modport belongs to the sequencer and memory side.
interface matmul_engine_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16,
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 16
);
  logic                     start;
  logic [DIM_W-1:0]         m;
  logic [DIM_W-1:0]         n;
  logic [DIM_W-1:0]         k;
  logic [ADDR_W-1:0]        a_base;
  logic [ADDR_W-1:0]        b_base;
  logic [ADDR_W-1:0]        c_base;
  logic                     busy;
  logic                     done;
  logic                     ovf;
  logic [ADDR_W-1:0]        a_addr;
  logic [ADDR_W-1:0]        b_addr;
  logic signed [DATA_W-1:0] a_data;
  logic signed [DATA_W-1:0] b_data;
  logic [ADDR_W-1:0]        c_addr;
  logic signed [OUT_W-1:0]  c_data;
  logic                     c_we;

  modport master (
    output start, m, n, k, a_base, b_base, c_base, a_data, b_data,
    input  busy, done, ovf, a_addr, b_addr, c_addr, c_data, c_we
  );

  modport slave (
    input  start, m, n, k, a_base, b_base, c_base, a_data, b_data,
    output busy, done, ovf, a_addr, b_addr, c_addr, c_data, c_we
  );
endinterface

// File: rtl/matmul_engine.sv
// Pipelined signed fixed-point C = A*B engine with row-major external memories.
// Define MATMUL_RELU_EN to write negative results as zero.
module matmul_engine #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 16,
  parameter int FRAC   = 8,
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input logic            clk,
  input logic            rst_n,
  matmul_engine_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;

  state_t                   state;
  logic [DIM_W-1:0]         m_r, n_r, k_r;
  logic [DIM_W-1:0]         i, j, p;
  logic [ADDR_W-1:0]        b_base_r, a_row, b_col, c_ptr;
  logic [ADDR_W-1:0]        a_addr, b_addr, c_addr;
  logic signed [OUT_W-1:0]  c_data;
  logic                     c_we, busy, done, ovf;
  logic [RD_LAT-1:0]        vld_sr, first_sr, last_sr;
  logic signed [ACC_W-1:0]  acc, acc_nxt, shifted;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [OUT_W-1:0]  sat_val;
  logic                     sat_hit;
  logic                     p_last, j_last, i_last, issue;

  assign p_last = (p == k_r - 1'b1);
  assign j_last = (j == n_r - 1'b1);
  assign i_last = (i == m_r - 1'b1);
  assign issue  = (state == RUN);

  assign bus.a_addr = a_addr;
  assign bus.b_addr = b_addr;
  assign bus.c_addr = c_addr;
  assign bus.c_data = c_data;
  assign bus.c_we   = c_we;
  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.ovf    = ovf;

  // The first product of an element overwrites the accumulator, so no clear cycle is needed.
  always_comb begin
    prod    = $signed(bus.a_data) * $signed(bus.b_data);
    acc_nxt = (first_sr[RD_LAT-1] ? '0 : acc) + ACC_W'(prod);
    shifted = acc_nxt >>> FRAC;
    sat_val = shifted[OUT_W-1:0];
    sat_hit = 1'b0;
    if (!shifted[ACC_W-1] && (|shifted[ACC_W-2:OUT_W-1])) begin
      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
      sat_hit = 1'b1;
    end
`ifdef MATMUL_RELU_EN
    else if (shifted[ACC_W-1]) begin
      sat_val = '0;
    end
`else
    else if (shifted[ACC_W-1] && !(&shifted[ACC_W-2:OUT_W-1])) begin
      sat_val = {1'b1, {(OUT_W-1){1'b0}}};
      sat_hit = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      m_r      <= '0;
      n_r      <= '0;
      k_r      <= '0;
      i        <= '0;
      j        <= '0;
      p        <= '0;
      b_base_r <= '0;
      a_row    <= '0;
      b_col    <= '0;
      c_ptr    <= '0;
      a_addr   <= '0;
      b_addr   <= '0;
      c_addr   <= '0;
      c_data   <= '0;
      c_we     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      vld_sr   <= '0;
      first_sr <= '0;
      last_sr  <= '0;
      acc      <= '0;
    end else begin
      // Tag bits travel alongside each issued address for RD_LAT cycles.
      vld_sr   <= RD_LAT'({vld_sr, issue});
      first_sr <= RD_LAT'({first_sr, issue && (p == '0)});
      last_sr  <= RD_LAT'({last_sr, issue && p_last});
      if (vld_sr[RD_LAT-1]) acc <= acc_nxt;
      done <= 1'b0;
      c_we <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            m_r <= bus.m;
            n_r <= bus.n;
            k_r <= bus.k;
            i   <= '0;
            j   <= '0;
            p   <= '0;
            ovf <= 1'b0;
            if (bus.m == '0 || bus.n == '0 || bus.k == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= RUN;
              busy     <= 1'b1;
              b_base_r <= bus.b_base;
              a_row    <= bus.a_base;
              b_col    <= bus.b_base;
              c_ptr    <= bus.c_base;
              a_addr   <= bus.a_base;
              b_addr   <= bus.b_base;
            end
          end
        end
        RUN: begin
          if (p_last) begin
            state <= DRAIN;
          end else begin
            p      <= p + 1'b1;
            a_addr <= a_addr + 1'b1;
            b_addr <= b_addr + ADDR_W'(n_r);
          end
        end
        DRAIN: begin
          if (vld_sr[RD_LAT-1] && last_sr[RD_LAT-1]) begin
            c_data <= sat_val;
            c_addr <= c_ptr;
            c_we   <= 1'b1;
            ovf    <= ovf | sat_hit;
            state  <= WRITE;
          end
        end
        WRITE: begin
          c_ptr <= c_ptr + 1'b1;
          p     <= '0;
          if (i_last && j_last) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (j_last) begin
            state  <= RUN;
            j      <= '0;
            i      <= i + 1'b1;
            a_row  <= a_row + ADDR_W'(k_r);
            a_addr <= a_row + ADDR_W'(k_r);
            b_col  <= b_base_r;
            b_addr <= b_base_r;
          end else begin
            state  <= RUN;
            j      <= j + 1'b1;
            b_col  <= b_col + 1'b1;
            a_addr <= a_row;
            b_addr <= b_col + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Parametrised, pipelined signed fixed-point matrix-multiply engine computing C = A·B, with A (m×k), B (k×n) and C (m×n) stored row-major in external synchronous memories at programmable base addresses. It is the next-generation compute core for the NN layer sequencer. It issues one operand-address pair per cycle, tolerates a configurable memory read latency, rescales and saturates each dot product to the output width, and reports overflow. The layer FSM drives it with a start/done handshake.

## Interface
Parameters:
- DATA_W, 16: signed operand width (A and B elements)
- ACC_W, 40: signed accumulator width; must be ≥ 2·DATA_W
- OUT_W, 16: signed output element width
- FRAC, 8: arithmetic right shift applied to the accumulator before saturation
- DIM_W, 10: width of the m/n/k dimension inputs
- ADDR_W, 16: memory address width
- RD_LAT, 1: memory read latency in cycles, 1..4

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- m, n, k  in  DIM_W each  matrix dimensions; latched on accepted start
- a_base, b_base, c_base  in  ADDR_W each  base addresses; latched on accepted start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at completion
- ovf  out  1  sticky; set if any output element saturated; cleared on accepted start
- a_addr, b_addr  out  ADDR_W  read addresses; data returns RD_LAT cycles later
- a_data, b_data  in  DATA_W  signed read data
- c_addr  out  ADDR_W  write address
- c_data  out  OUT_W  write data
- c_we  out  1  write strobe, one cycle per element

## Operation
- States: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE: on start, latch dims and bases, clear ovf, set i=j=p=0, and go to RUN. If any of m, n or k is 0, go directly to DONE with no reads or writes.
- RUN: each cycle present a_addr = a_base + i·k + p and b_addr = b_base + p·n + j, with a valid bit entering an RD_LAT-deep shift register. Increment p. After p = k−1 is issued, go to DRAIN.
- Accumulate whenever the delayed valid bit is high: acc <= (first product ? 0 : acc) + sext(a_data·b_data). The first product of each element overwrites acc; there is no separate clear cycle.
- DRAIN: wait until the last product of the element is accumulated, then go to WRITE.
- WRITE: c_addr = c_base + i·n + j, c_data = sat(acc >>> FRAC), c_we = 1. Then advance j; when j = n−1, set j = 0 and increment i. Set p = 0. If (i, j) was (m−1, n−1), go to DONE; otherwise go to RUN.
- DONE: done = 1 for one cycle, busy = 0, return to IDLE.
- Arithmetic: products are full 2·DATA_W signed values and are sign-extended to ACC_W. The accumulator wraps modulo 2^ACC_W with no detection. The shift is arithmetic. Saturation clamps to [−2^(OUT_W−1), 2^(OUT_W−1)−1] and sets ovf.
- All address arithmetic wraps modulo 2^ADDR_W.
- start while busy is ignored. Dimensions and bases are not re-sampled mid-run.
- Reset mid-operation: everything returns to IDLE immediately. Outputs take their reset values, and any in-flight read data is discarded.

## Timing
- Reset values: busy=0, done=0, ovf=0, c_we=0, a_addr=b_addr=c_addr=0, c_data=0.
- Accepted start at cycle 0: the first address pair appears at cycle 1.
- Per element: k RUN cycles, RD_LAT DRAIN cycles, 1 WRITE cycle, for k+RD_LAT+1 cycles per element.
- Total latency: done pulses at cycle 1 + m·n·(k+RD_LAT+1).
- Zero-dimension case: done pulses at cycle 1.
- c_we is never high in two consecutive cycles. done never coincides with c_we.
- Addresses are registered outputs and are held stable outside RUN.

## Configuration
- MATMUL_RELU_EN defined: negative shifted accumulator values are written as 0. ovf can then only be set by positive saturation.
- MATMUL_RELU_EN undefined: signed saturation only, with no extra logic.

## Test plan
- 2×3·3×2 identity test (A = [[1,2,3],[4,5,6]] in Q8.8, B = rows of I padded with zeros, FRAC=8), RD_LAT=1. Required: C = [[1,2],[4,5]] (0x0100, 0x0200, 0x0400, 0x0500) at c_base+0..3; done at cycle 1+4·5=21; ovf=0.
- Same matrices with RD_LAT=3. Required: identical results; done at cycle 1+4·7=29; c_we pulses spaced 7 cycles apart.
- m=1, n=1, k=1, operands 0x7FFF·0x7FFF, FRAC=0. Required: c_data=0x7FFF, ovf=1. With MATMUL_RELU_EN and operands 0x8000·0x0001, required: c_data=0.
- m=0 (or k=0). Required: done at cycle 1, no c_we, busy low after done.
- Assert start mid-run, and also assert rst_n low during the 3rd element. Required: the mid-run start is ignored; reset drives busy=0 and c_we=0 immediately; a fresh start afterwards produces correct results.
- c_base = 0xFFFE with 2×2 output. Required: writes land at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
